mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates the single-ported, byte-addressed main memory between the instruction-fetch unit and the load/store unit of the RV32 core. It sequences every memory cycle: word reads, full-word writes and read-modify-write sequences for sub-word stores. Data accesses have priority, with a bounded-starvation guarantee for fetch. The block sits between the core's two memory clients and the main memory's `address`/`data_in`/`data_out`/`read_write` port.

## Interface
- STARTING_ADDR, 'h01000000, base address of main memory; value driven on mem_address in reset/idle
- MAX_DATA_BURST, 4, consecutive data grants allowed while fetch waits (range 1..15)
- clock  in  1  system clock, all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  32  fetch byte address
- i_ack  out  1  fetch access cycle; i_rdata valid this cycle
- i_rdata  out  32  fetched word (from mem_data_out)
- d_req  in  1  data request; held with all d_* inputs until d_ack
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- d_addr  in  32  data byte address (alignment not required)
- d_wdata  in  32  store data, right-justified
- d_ack  out  1  data access complete this cycle
- d_rdata  out  32  loaded word (full 32 bits at d_addr; extension is done by the LSU)
- d_err  out  1  qualifies d_ack; request had reserved size
- mem_address  out  32  to main memory address
- mem_data_in  out  32  to main memory data_in
- mem_data_out  in  32  from main memory data_out (combinational read)
- mem_read_write  out  1  0 = READ, 1 = WRITE

## Operation
- States: IDLE, FETCH, DREAD, DWRITE, RMW_RD, RMW_WR.
- IDLE: mem_read_write = READ and mem_address = STARTING_ADDR. The block selects a requester:
  - Data wins by default.
  - Fetch wins if only i_req is set, or if burst_cnt == MAX_DATA_BURST.
- Data target state:
  - Load → DREAD.
  - Store with size 10, or with size 00/01 when RMW is compiled out → DWRITE.
  - Store with size 00/01 when RMW is compiled in → RMW_RD.
  - Size 11 (load or store) → no memory access; d_ack and d_err pulse in the next cycle while the state stays IDLE for that one cycle.
- FETCH / DREAD:
  - Drive the address with READ.
  - Assert the ack; rdata = mem_data_out.
  - Return to IDLE.
- DWRITE:
  - Drive d_addr, d_wdata, WRITE.
  - Memory commits at the closing posedge.
  - d_ack is high this cycle; return to IDLE.
- RMW_RD:
  - Read at d_addr.
  - At the posedge, latch merge = byte: {rd[31:8], wdata[7:0]}; half: {rd[31:16], wdata[15:0]}.
  - Go to RMW_WR.
- RMW_WR:
  - Write merge at d_addr.
  - d_ack is high; return to IDLE.
- burst_cnt (4-bit):
  - Increments on each data grant made while i_req is high.
  - Clears on a fetch grant, or in any IDLE cycle with i_req low.
  - Saturates at MAX_DATA_BURST.
- Every access returns to IDLE. The requester must drop or renew req at the edge ending its ack cycle, so no request is double-counted.

## Timing
- Reset values (asynchronous): state IDLE, burst_cnt 0, merge register 0, mem_address STARTING_ADDR, mem_data_in 0, mem_read_write READ. i_ack, d_ack, d_err are 0; i_rdata and d_rdata are 0.
- All outputs decode from registered state (Moore), except rdata, which passes through from mem_data_out during the ack cycle.
- Latency from req first seen in IDLE (cycle N):
  - Read / word write: ack in N+1.
  - RMW: ack in N+2.
  - Reserved size: ack + err in N+1.
- Throughput: one access per 2 cycles (RMW: 3).
- Both requests arriving in the same cycle: data is granted and fetch waits. Fetch is guaranteed a grant within MAX_DATA_BURST data accesses.
- Requests arriving in a non-IDLE cycle are held by the requester and evaluated at the next IDLE.
- Reset asserted mid-access:
  - mem_read_write drops to READ immediately, so an aborted DWRITE or RMW_WR does not commit.
  - An aborted RMW_RD leaves memory unchanged.
  - No ack is issued.

## Configuration
- MEM_ARB_RMW_EN defined: sub-word stores use RMW_RD→RMW_WR, and memory bytes outside the stored size are preserved.
- MEM_ARB_RMW_EN undefined: RMW states and the merge register are absent, and d_size 00/01 stores go through DWRITE writing all 4 bytes of d_wdata. Reserved-size handling is unchanged.

## Structure
- Package mem_arb_pkg holds:
  - the state enum
  - READ/WRITE constants (0/1)
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD
- One sub-module, store_merge: combinational (rd_word, wdata, size) → merged word. It is instantiated only under MEM_ARB_RMW_EN.

## Test plan
- Fetch only, i_addr 0x01000000 then 0x01000004, memory preloaded 0x00000013, 0x00100093: i_ack one cycle after each req is seen, i_rdata matches, spacing 2 cycles.
- Simultaneous i_req and d_req (load 0x01000100 = 0xDEADBEEF), MAX_DATA_BURST = 4: d_ack first with d_rdata 0xDEADBEEF; i_ack follows 2 cycles later.
- d_req held for 6 loads with i_req held: the fetch grant occurs after exactly 4 data acks; burst_cnt then restarts.
- Store byte 0xA5 to 0x01000100 holding 0x11223344 (RMW on): d_ack 2 cycles after accept, then a word load returns 0x112233A5. Same store with RMW off returns 0x000000A5.
- d_size 11 load: d_ack and d_err high for one cycle, with no WRITE cycle on mem_read_write.
- reset_n pulsed low during RMW_WR: mem_read_write goes to 0 asynchronously, memory still reads 0x11223344, no d_ack, and state is IDLE after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DREAD,
    ST_DWRITE,
    ST_RMW_RD,
    ST_RMW_WR
  } state_e;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

endpackage

// File: rtl/mem_port_arbiter_store_merge.sv
// Merges a right-justified sub-word store into the word read back from memory.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module store_merge
  import mem_arb_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic [31:0] merged
);

  // Keep the memory bytes above the stored size, replace the low ones.
  always_comb begin
    merged = wdata;
    case (size)
      SZ_BYTE: merged = {rd_word[31:8], wdata[7:0]};
      SZ_HALF: merged = {rd_word[31:16], wdata[15:0]};
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between fetch and load/store; MEM_ARB_RMW_EN enables sub-word RMW stores.
// Latency: read/word write/reserved-size ack one cycle after the req is seen in IDLE, RMW two.
// Backpressure: requesters hold req until ack; data wins, fetch wins after MAX_DATA_BURST data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter logic [31:0] STARTING_ADDR  = 32'h0100_0000,
  parameter int unsigned MAX_DATA_BURST = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        mem_read_write
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  state_e     state_q, state_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  // Reserved-size requests never touch memory; this flop is their one-cycle ack.
  logic       err_q, err_d;
  logic       fetch_win;

  // Fetch only gets the port when data is absent or has used up its burst allowance.
  assign fetch_win = i_req && (!d_req || (burst_cnt_q == BURST_MAX));

`ifdef MEM_ARB_RMW_EN
  logic [31:0] merge_q, merge_d, merge_word;

  store_merge u_store_merge (
    .rd_word (mem_data_out),
    .wdata   (d_wdata),
    .size    (d_size),
    .merged  (merge_word)
  );

  // Capture the merged word at the end of the RMW read cycle.
  always_comb begin
    merge_d = merge_q;
    if (state_q == ST_RMW_RD) merge_d = merge_word;
  end
`endif

  // Next-state, burst counter and reserved-size ack selection.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // During the reserved-size ack cycle the request is still held, so no grant.
        if (!err_q) begin
          if (fetch_win) begin
            state_d     = ST_FETCH;
            burst_cnt_d = 4'd0;
          end else if (d_req) begin
            if (i_req && (burst_cnt_q != BURST_MAX)) burst_cnt_d = burst_cnt_q + 4'd1;
            if (d_size == SZ_RSVD) begin
              err_d = 1'b1;
            end else if (!d_we) begin
              state_d = ST_DREAD;
            end else if (d_size == SZ_WORD) begin
              state_d = ST_DWRITE;
            end else begin
`ifdef MEM_ARB_RMW_EN
              state_d = ST_RMW_RD;
`else
              state_d = ST_DWRITE;
`endif
            end
          end
        end
        if (!i_req) burst_cnt_d = 4'd0;
      end
      ST_RMW_RD: state_d = ST_RMW_WR;
      default:   state_d = ST_IDLE;
    endcase
  end

  // All state resets asynchronously so an aborted write drops to READ at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= 4'd0;
      err_q       <= 1'b0;
`ifdef MEM_ARB_RMW_EN
      merge_q     <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      err_q       <= err_d;
`ifdef MEM_ARB_RMW_EN
      merge_q     <= merge_d;
`endif
    end
  end

  // Moore decode of the memory port and acks; rdata passes through in the ack cycle.
  always_comb begin
    mem_address    = STARTING_ADDR;
    mem_data_in    = 32'd0;
    mem_read_write = READ;
    i_ack          = 1'b0;
    i_rdata        = 32'd0;
    d_ack          = err_q;
    d_err          = err_q;
    d_rdata        = 32'd0;
    case (state_q)
      ST_FETCH: begin
        mem_address = i_addr;
        i_ack       = 1'b1;
        i_rdata     = mem_data_out;
      end
      ST_DREAD: begin
        mem_address = d_addr;
        d_ack       = 1'b1;
        d_rdata     = mem_data_out;
      end
      ST_DWRITE: begin
        mem_address    = d_addr;
        mem_data_in    = d_wdata;
        mem_read_write = WRITE;
        d_ack          = 1'b1;
      end
`ifdef MEM_ARB_RMW_EN
      ST_RMW_RD: begin
        mem_address = d_addr;
      end
      ST_RMW_WR: begin
        mem_address    = d_addr;
        mem_data_in    = merge_q;
        mem_read_write = WRITE;
        d_ack          = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a word-wide behavioural memory.
// Latency: checks ack timing against the documented per-access latencies.
// Backpressure: requests are held until ack and dropped at the edge ending the ack cycle.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam logic [31:0] BASE = 32'h0100_0000;

`ifdef MEM_ARB_RMW_EN
  localparam int          SUB_LAT  = 2;
  localparam logic [31:0] BYTE_EXP = 32'h1122_33A5;
  localparam logic [31:0] HALF_EXP = 32'h5566_BEEF;
`else
  localparam int          SUB_LAT  = 1;
  localparam logic [31:0] BYTE_EXP = 32'h0000_00A5;
  localparam logic [31:0] HALF_EXP = 32'hCAFE_BEEF;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'b10;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_read_write;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural memory: combinational read, write at posedge, plus a preload port.
  logic [31:0] mem [0:255];
  logic        pl_vld = 1'b0;
  logic [7:0]  pl_idx = '0;
  logic [31:0] pl_dat = '0;
  assign mem_data_out = mem[mem_address[9:2]];
  always @(posedge clock) begin
    if (pl_vld) mem[pl_idx] <= pl_dat;
    else if (mem_read_write) mem[mem_address[9:2]] <= mem_data_in;
  end

  mem_port_arbiter #(.STARTING_ADDR(BASE), .MAX_DATA_BURST(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_read_write(mem_read_write)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] dat);
    pl_vld = 1'b1; pl_idx = idx; pl_dat = dat;
    @(posedge clock); #1;
    pl_vld = 1'b0;
  endtask

  // Called at posedge+1 with the DUT in IDLE; k counts cycles from the one the req is seen in.
  task automatic data_xact(input logic we, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] w, output logic [31:0] rd, output logic err,
                           output int lat, output logic saw_wr);
    d_req = 1'b1; d_we = we; d_size = sz; d_addr = a; d_wdata = w;
    lat = -1; rd = '0; err = 1'b0; saw_wr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (mem_read_write) saw_wr = 1'b1;
      if (d_ack) begin
        lat = k; rd = d_rdata; err = d_err;
        break;
      end
    end
    @(posedge clock); #1;
    d_req = 1'b0;
  endtask

  task automatic fetch_xact(input logic [31:0] a, output logic [31:0] rd, output int lat,
                            output int ack_cyc);
    i_req = 1'b1; i_addr = a;
    lat = -1; rd = '0; ack_cyc = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (i_ack) begin
        lat = k; rd = i_rdata; ack_cyc = cyc;
        break;
      end
    end
    @(posedge clock); #1;
    i_req = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic        chk_rd;
    logic [31:0] rd;
    logic        wr;
  } vec_t;

  vec_t vec [9];

  initial begin
    logic [31:0] rd;
    logic        err, saw_wr;
    int          lat, c0, c1, t0, d_cyc, i_cyc;
    int          dacks, iacks, d_before, d_between;
    logic [31:0] d_rd, i_rd;

    vec[0] = '{"st_word",      1'b1, SZ_WORD, BASE + 32'h100, 32'h1122_3344, 1,       1'b0, 1'b0, 32'h0,    1'b1};
    vec[1] = '{"st_byte",      1'b1, SZ_BYTE, BASE + 32'h100, 32'h0000_00A5, SUB_LAT, 1'b0, 1'b0, 32'h0,    1'b1};
    vec[2] = '{"ld_after_byte",1'b0, SZ_WORD, BASE + 32'h100, 32'h0,          1,       1'b0, 1'b1, BYTE_EXP, 1'b0};
    vec[3] = '{"st_word2",     1'b1, SZ_WORD, BASE + 32'h104, 32'h5566_7788, 1,       1'b0, 1'b0, 32'h0,    1'b1};
    vec[4] = '{"st_half",      1'b1, SZ_HALF, BASE + 32'h104, 32'hCAFE_BEEF, SUB_LAT, 1'b0, 1'b0, 32'h0,    1'b1};
    vec[5] = '{"ld_after_half",1'b0, SZ_WORD, BASE + 32'h104, 32'h0,          1,       1'b0, 1'b1, HALF_EXP, 1'b0};
    vec[6] = '{"ld_rsvd",      1'b0, SZ_RSVD, BASE + 32'h100, 32'h0,          1,       1'b1, 1'b1, 32'h0,    1'b0};
    vec[7] = '{"st_rsvd",      1'b1, SZ_RSVD, BASE + 32'h100, 32'hFFFF_FFFF, 1,       1'b1, 1'b0, 32'h0,    1'b0};
    vec[8] = '{"ld_unchanged", 1'b0, SZ_WORD, BASE + 32'h100, 32'h0,          1,       1'b0, 1'b1, BYTE_EXP, 1'b0};

    // Reset state, before any clock edge.
    #1;
    chk("rst_mem_address", mem_address, BASE);
    chk("rst_mem_rw", 32'(mem_read_write), 32'(READ));
    chk("rst_mem_data_in", mem_data_in, 32'h0);
    chk("rst_acks", {29'd0, i_ack, d_ack, d_err}, 32'h0);
    chk("rst_rdata", i_rdata | d_rdata, 32'h0);

    preload(8'd0, 32'h0000_0013);
    preload(8'd1, 32'h0010_0093);
    preload(8'd64, 32'hDEAD_BEEF);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Fetch only, back-to-back with the request renewed at the ack edge.
    fetch_xact(BASE, rd, lat, c0);
    chk("fetch0_lat", 32'(lat), 32'd1);
    chk("fetch0_rdata", rd, 32'h0000_0013);
    fetch_xact(BASE + 32'h4, rd, lat, c1);
    chk("fetch1_lat", 32'(lat), 32'd1);
    chk("fetch1_rdata", rd, 32'h0010_0093);
    chk("fetch_spacing", 32'(c1 - c0), 32'd2);

    // Simultaneous requests: data first, fetch two cycles later.
    t0 = cyc; d_cyc = -1; i_cyc = -1; d_rd = '0; i_rd = '0;
    i_req = 1'b1; i_addr = BASE;
    d_req = 1'b1; d_we = 1'b0; d_size = SZ_WORD; d_addr = BASE + 32'h100;
    for (int k = 0; k < 12 && (d_cyc < 0 || i_cyc < 0); k++) begin
      @(negedge clock);
      if (d_ack) begin d_cyc = cyc; d_rd = d_rdata; end
      if (i_ack) begin i_cyc = cyc; i_rd = i_rdata; end
      @(posedge clock); #1;
      if (d_cyc >= 0) d_req = 1'b0;
      if (i_cyc >= 0) i_req = 1'b0;
    end
    chk("sim_dack_cycle", 32'(d_cyc - t0), 32'd1);
    chk("sim_drdata", d_rd, 32'hDEAD_BEEF);
    chk("sim_iack_cycle", 32'(i_cyc - t0), 32'd3);
    chk("sim_irdata", i_rd, 32'h0000_0013);

    // Six held loads against a held fetch: 4 data acks, fetch, then 2 more.
    dacks = 0; iacks = 0; d_before = -1; d_between = 0;
    i_req = 1'b1; i_addr = BASE;
    d_req = 1'b1; d_we = 1'b0; d_size = SZ_WORD; d_addr = BASE + 32'h100;
    for (int k = 0; k < 60 && (iacks < 2 || dacks < 6); k++) begin
      @(negedge clock);
      if (d_ack) begin
        dacks++;
        if (iacks == 1) d_between++;
      end
      if (i_ack) begin
        iacks++;
        if (iacks == 1) d_before = dacks;
      end
      @(posedge clock); #1;
      if (dacks >= 6) d_req = 1'b0;
      if (iacks >= 2) i_req = 1'b0;
    end
    chk("burst_before_fetch", 32'(d_before), 32'd4);
    chk("burst_after_fetch", 32'(d_between), 32'd2);
    chk("burst_iacks", 32'(iacks), 32'd2);

    // Table-driven data accesses.
    for (int i = 0; i < 9; i++) begin
      data_xact(vec[i].we, vec[i].sz, vec[i].addr, vec[i].wdata, rd, err, lat, saw_wr);
      chk({vec[i].name, "_lat"}, 32'(lat), 32'(vec[i].lat));
      chk({vec[i].name, "_err"}, 32'(err), 32'(vec[i].err));
      chk({vec[i].name, "_wr"}, 32'(saw_wr), 32'(vec[i].wr));
      if (vec[i].chk_rd) chk({vec[i].name, "_rdata"}, rd, vec[i].rd);
    end

    // Reset pulsed during the write cycle of a sub-word store.
    preload(8'd64, 32'h1122_3344);
    d_req = 1'b1; d_we = 1'b1; d_size = SZ_BYTE; d_addr = BASE + 32'h100; d_wdata = 32'h0000_00A5;
    repeat (SUB_LAT) @(posedge clock);
    #2;
    chk("abort_pre_rw", 32'(mem_read_write), 32'(WRITE));
    reset_n = 1'b0;
    #1;
    chk("abort_rw_async", 32'(mem_read_write), 32'(READ));
    chk("abort_no_ack", 32'(d_ack), 32'd0);
    d_req = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("abort_idle_addr", mem_address, BASE);
    chk("abort_idle_acks", {30'd0, i_ack, d_ack}, 32'h0);
    @(posedge clock); #1;
    data_xact(1'b0, SZ_WORD, BASE + 32'h100, 32'h0, rd, err, lat, saw_wr);
    chk("abort_mem_kept", rd, 32'h1122_3344);
    chk("abort_reload_lat", 32'(lat), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
